// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: groups the IF fetch port, the MEM data port and the
// unified memory bus. The arbiter connects through the slave modport; the
// pipeline/memory environment drives the master modport.
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // IF fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  // MEM-stage data port
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;
  // unified memory bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_timeout;

  modport slave (
    input  if_req, if_addr, mem_ce, mem_we, mem_addr, mem_wdata, bus_ack, bus_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_timeout
  );

  modport master (
    output if_req, if_addr, mem_ce, mem_we, mem_addr, mem_wdata, bus_ack, bus_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_timeout
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one memory bus between the IF fetch port and the
// MEM data port. One access is outstanding at a time; ties alternate, starting
// with MEM. Each access ends on bus_ack or on a wait timeout, and is followed
// by one IDLE cycle in which the winner sees its one-cycle valid pulse.
module dmem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dmem_port_arbiter_if.slave io_arb
);

  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SRV_MEM = 2'd1,
    ST_SRV_IF  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_mem, w_last_mem_nxt;   // 1: MEM was served last
  logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic              r_bus_req, w_bus_req_nxt;
  logic              r_bus_we, w_bus_we_nxt;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
  logic              r_if_valid, w_if_valid_nxt;
  logic              r_mem_valid, w_mem_valid_nxt;
  logic              r_bus_timeout, w_bus_timeout_nxt;

  // A port whose valid pulse is showing this cycle has already been served;
  // its still-high request must not be granted a second time.
  logic w_if_pend, w_mem_pend, w_grant_mem, w_grant_if;
  logic w_timeout_hit, w_done, w_aborted;

  assign w_if_pend     = io_arb.if_req & ~r_if_valid;
  assign w_mem_pend    = io_arb.mem_ce & ~r_mem_valid;
  assign w_grant_mem   = w_mem_pend & (~w_if_pend | ~r_last_mem);
  assign w_grant_if    = w_if_pend & ~w_grant_mem;
  assign w_timeout_hit = TO_EN && (r_wait_cnt == CNT_LAST);
  assign w_done        = io_arb.bus_ack | w_timeout_hit;
  assign w_aborted     = ~io_arb.bus_ack & w_timeout_hit;

  // Next-state and next-register values for arbitration and access sequencing.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_mem_nxt    = r_last_mem;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_bus_req_nxt     = r_bus_req;
    w_bus_we_nxt      = r_bus_we;
    w_bus_addr_nxt    = r_bus_addr;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_if_rdata_nxt    = r_if_rdata;
    w_mem_rdata_nxt   = r_mem_rdata;
    w_if_valid_nxt    = 1'b0;
    w_mem_valid_nxt   = 1'b0;
    w_bus_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_mem) begin
          w_state_nxt     = ST_SRV_MEM;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = io_arb.mem_we;
          w_bus_addr_nxt  = io_arb.mem_addr;
          w_bus_wdata_nxt = io_arb.mem_wdata;
          w_wait_cnt_nxt  = {CNT_W{1'b0}};
        end else if (w_grant_if) begin
          w_state_nxt     = ST_SRV_IF;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = 1'b0;
          w_bus_addr_nxt  = io_arb.if_addr;
          w_bus_wdata_nxt = {DATA_W{1'b0}};
          w_wait_cnt_nxt  = {CNT_W{1'b0}};
        end else begin
          w_bus_req_nxt   = 1'b0;
        end
      end
      ST_SRV_MEM, ST_SRV_IF: begin
        if (w_done) begin
          // bus_ack beats a timeout landing in the same cycle
          w_state_nxt       = ST_IDLE;
          w_bus_req_nxt     = 1'b0;
          w_wait_cnt_nxt    = {CNT_W{1'b0}};
          w_last_mem_nxt    = (r_state == ST_SRV_MEM);
          w_bus_timeout_nxt = w_aborted;
          if (r_state == ST_SRV_MEM) begin
            // a dropped request is a flush: access completes, result discarded
            if (io_arb.mem_ce) begin
              w_mem_valid_nxt = 1'b1;
              if (w_aborted) begin
                w_mem_rdata_nxt = {DATA_W{1'b0}};
              end else if (!r_bus_we) begin
                w_mem_rdata_nxt = io_arb.bus_rdata;
              end else begin
                w_mem_rdata_nxt = r_mem_rdata;
              end
            end else begin
              w_mem_valid_nxt = 1'b0;
            end
          end else begin
            if (io_arb.if_req) begin
              w_if_valid_nxt = 1'b1;
              w_if_rdata_nxt = w_aborted ? {DATA_W{1'b0}} : io_arb.bus_rdata;
            end else begin
              w_if_valid_nxt = 1'b0;
            end
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus, result and bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last_mem    <= 1'b0;
      r_wait_cnt    <= {CNT_W{1'b0}};
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= {ADDR_W{1'b0}};
      r_bus_wdata   <= {DATA_W{1'b0}};
      r_if_rdata    <= {DATA_W{1'b0}};
      r_mem_rdata   <= {DATA_W{1'b0}};
      r_if_valid    <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_bus_timeout <= 1'b0;
    end else begin
      r_last_mem    <= w_last_mem_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_bus_req     <= w_bus_req_nxt;
      r_bus_we      <= w_bus_we_nxt;
      r_bus_addr    <= w_bus_addr_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_if_rdata    <= w_if_rdata_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_mem_valid   <= w_mem_valid_nxt;
      r_bus_timeout <= w_bus_timeout_nxt;
    end
  end

  assign io_arb.if_rdata    = r_if_rdata;
  assign io_arb.if_valid    = r_if_valid;
  assign io_arb.if_stall    = io_arb.if_req & ~r_if_valid;
  assign io_arb.mem_rdata   = r_mem_rdata;
  assign io_arb.mem_valid   = r_mem_valid;
  assign io_arb.mem_stall   = io_arb.mem_ce & ~r_mem_valid;
  assign io_arb.bus_req     = r_bus_req;
  assign io_arb.bus_we      = r_bus_we;
  assign io_arb.bus_addr    = r_bus_addr;
  assign io_arb.bus_wdata   = r_bus_wdata;
  assign io_arb.bus_timeout = r_bus_timeout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level reference model of the arbiter.
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: access on the bus (0 none, 1 IF, 2 MEM), bus cycles
  // spent on it so far, and which port was served last
  int            m_srv, m_cnt, m_last;
  logic          e_bus_req, e_bus_we, e_if_valid, e_mem_valid, e_to;
  logic [AW-1:0] e_bus_addr;
  logic [DW-1:0] e_bus_wdata, e_if_rdata, e_mem_rdata;

  int ack_delay = 1;   // bus cycle (1-based) on which the responder acks
  bit auto_new  = 1'b0;
  int cnt_if_v  = 0;
  int cnt_mem_v = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_arb (bus_if.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_srv = 0; m_cnt = 0; m_last = 1;
    e_bus_req = 1'b0; e_bus_we = 1'b0; e_bus_addr = '0; e_bus_wdata = '0;
    e_if_rdata = '0; e_mem_rdata = '0; e_if_valid = 1'b0; e_mem_valid = 1'b0; e_to = 1'b0;
  endtask

  // advance the model by one clock using the inputs present this cycle
  task automatic model_step();
    logic nv_if, nv_mem, nto, abort;
    bit   pi, pm;
    nv_if = 1'b0; nv_mem = 1'b0; nto = 1'b0;
    if (m_srv == 0) begin
      pi = bus_if.if_req && !e_if_valid;
      pm = bus_if.mem_ce && !e_mem_valid;
      if (pm && (!pi || m_last == 1)) begin
        m_srv = 2; m_cnt = 0;
        e_bus_we = bus_if.mem_we; e_bus_addr = bus_if.mem_addr; e_bus_wdata = bus_if.mem_wdata;
      end else if (pi) begin
        m_srv = 1; m_cnt = 0;
        e_bus_we = 1'b0; e_bus_addr = bus_if.if_addr; e_bus_wdata = '0;
      end
    end else begin
      m_cnt++;
      if (bus_if.bus_ack || m_cnt == TO) begin
        abort = !bus_if.bus_ack;
        nto   = abort;
        if (m_srv == 1) begin
          if (bus_if.if_req) begin
            nv_if = 1'b1;
            e_if_rdata = abort ? '0 : bus_if.bus_rdata;
          end
        end else begin
          if (bus_if.mem_ce) begin
            nv_mem = 1'b1;
            if (abort) e_mem_rdata = '0;
            else if (!e_bus_we) e_mem_rdata = bus_if.bus_rdata;
          end
        end
        m_last = m_srv;
        m_srv  = 0;
      end
    end
    e_if_valid = nv_if; e_mem_valid = nv_mem; e_to = nto;
    e_bus_req  = (m_srv != 0);
  endtask

  task automatic check_outs();
    check_val("bus_req", bus_if.bus_req, e_bus_req);
    check_val("if_valid", bus_if.if_valid, e_if_valid);
    check_val("mem_valid", bus_if.mem_valid, e_mem_valid);
    check_val("bus_timeout", bus_if.bus_timeout, e_to);
    check_val("if_rdata", bus_if.if_rdata, e_if_rdata);
    check_val("mem_rdata", bus_if.mem_rdata, e_mem_rdata);
    if (e_bus_req) begin
      check_val("bus_we", bus_if.bus_we, e_bus_we);
      check_val("bus_addr", bus_if.bus_addr, e_bus_addr);
      check_val("bus_wdata", bus_if.bus_wdata, e_bus_wdata);
    end
  endtask

  // requesters drop on valid; in random mode they also issue, flush and the
  // bus responder picks per-access latencies (some beyond the timeout)
  task automatic drive();
    int r;
    if (e_if_valid) bus_if.if_req = 1'b0;
    if (e_mem_valid) bus_if.mem_ce = 1'b0;
    if (auto_new) begin
      if (!bus_if.if_req && $urandom_range(3, 0) == 0) begin
        bus_if.if_req = 1'b1; bus_if.if_addr = $urandom;
      end
      if (!bus_if.mem_ce && $urandom_range(3, 0) == 0) begin
        bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'($urandom_range(1, 0));
        bus_if.mem_addr = $urandom; bus_if.mem_wdata = $urandom;
      end
      if (m_srv == 1 && bus_if.if_req && $urandom_range(19, 0) == 0) bus_if.if_req = 1'b0;
      if (m_srv == 2 && bus_if.mem_ce && $urandom_range(19, 0) == 0) bus_if.mem_ce = 1'b0;
      if (m_srv != 0 && m_cnt == 0) begin
        r = $urandom_range(9, 0);
        if (r < 6) ack_delay = $urandom_range(3, 1);
        else if (r < 8) ack_delay = $urandom_range(10, 4);
        else if (r == 8) ack_delay = TO;
        else ack_delay = TO + 1;
      end
      bus_if.bus_rdata = $urandom;
    end
    if (m_srv != 0) bus_if.bus_ack = (m_cnt + 1 == ack_delay);
    else bus_if.bus_ack = auto_new && ($urandom_range(2, 0) == 0);
  endtask

  task automatic tick();
    #1;
    check_val("if_stall", bus_if.if_stall, bus_if.if_req & ~e_if_valid);
    check_val("mem_stall", bus_if.mem_stall, bus_if.mem_ce & ~e_mem_valid);
    model_step();
    @(posedge clk);
    #1;
    if (bus_if.if_valid) cnt_if_v++;
    if (bus_if.mem_valid) cnt_mem_v++;
    check_outs();
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.if_req = 1'b0; bus_if.if_addr = '0;
    bus_if.mem_ce = 1'b0; bus_if.mem_we = 1'b0; bus_if.mem_addr = '0; bus_if.mem_wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    model_reset();
    #1;
    check_outs();
    check_val("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check_val("rst_bus_we", bus_if.bus_we, 1'b0);
    check_val("rst_if_stall", bus_if.if_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();

    // IF-only read: bus_req at cycle 1, ack at cycle 2, if_valid at cycle 3
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h40; bus_if.bus_rdata = 32'h13; ack_delay = 2;
    step();
    check_val("t1_bus_req_c1", bus_if.bus_req, 1'b1);
    run(2);
    check_val("t1_if_valid_c3", bus_if.if_valid, 1'b1);
    check_val("t1_if_rdata", bus_if.if_rdata, 32'h13);
    step();

    // IF flushed while being served: no valid, old data kept, next request served
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h300; bus_if.bus_rdata = 32'h77; ack_delay = 3;
    run(2);
    bus_if.if_req = 1'b0;
    run(2);
    check_val("t4_no_if_valid", bus_if.if_valid, 1'b0);
    check_val("t4_if_rdata_kept", bus_if.if_rdata, 32'h13);
    cnt_if_v = 0;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h304; bus_if.bus_rdata = 32'hCAFE0001; ack_delay = 1;
    run(4);
    check_val("t4_next_if_served", cnt_if_v, 1);

    // timeout: no ack for 16 bus cycles
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h400; ack_delay = 1000;
    run(16);
    check_val("t5_bus_req_c16", bus_if.bus_req, 1'b1);
    check_val("t5_no_to_c16", bus_if.bus_timeout, 1'b0);
    step();
    check_val("t5_timeout", bus_if.bus_timeout, 1'b1);
    check_val("t5_if_valid", bus_if.if_valid, 1'b1);
    check_val("t5_if_rdata_zero", bus_if.if_rdata, 32'h0);
    run(2);
    // ack on the 16th bus cycle completes normally
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h404; bus_if.bus_rdata = 32'h5555AAAA; ack_delay = TO;
    run(17);
    check_val("t5b_no_timeout", bus_if.bus_timeout, 1'b0);
    check_val("t5b_if_valid", bus_if.if_valid, 1'b1);
    check_val("t5b_if_rdata", bus_if.if_rdata, 32'h5555AAAA);
    run(2);

    // tie after reset: MEM first, then IF, then MEM wins the next tie
    do_reset();
    cnt_if_v = 0; cnt_mem_v = 0;
    bus_if.bus_rdata = 32'h11111111; ack_delay = 1;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h80;
    bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h100;
    step();
    check_val("t2_mem_first", bus_if.bus_addr, 32'h100);
    run(7);
    check_val("t2_if_served", cnt_if_v, 1);
    check_val("t2_mem_served", cnt_mem_v, 1);
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h84;
    bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h104;
    step();
    check_val("t2_tie_mem_again", bus_if.bus_addr, 32'h104);
    run(7);

    // store, ack on the 5th bus cycle
    do_reset();
    cnt_mem_v = 0;
    bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 32'h200;
    bus_if.mem_wdata = 32'hDEADBEEF; bus_if.bus_rdata = 32'h12345678; ack_delay = 5;
    step();
    check_val("t3_bus_we", bus_if.bus_we, 1'b1);
    check_val("t3_bus_wdata", bus_if.bus_wdata, 32'hDEADBEEF);
    run(9);
    check_val("t3_mem_valid_once", cnt_mem_v, 1);
    check_val("t3_mem_rdata_kept", bus_if.mem_rdata, 32'h0);

    // asynchronous reset in the middle of a MEM access
    bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h500; ack_delay = 10;
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_bus_req", bus_if.bus_req, 1'b0);
    check_val("t6_async_mem_valid", bus_if.mem_valid, 1'b0);
    check_val("t6_async_timeout", bus_if.bus_timeout, 1'b0);
    do_reset();
    cnt_mem_v = 0;
    bus_if.mem_ce = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h504;
    bus_if.bus_rdata = 32'h0BADF00D; ack_delay = 2;
    run(5);
    check_val("t6_fresh_served", cnt_mem_v, 1);
    check_val("t6_fresh_rdata", bus_if.mem_rdata, 32'h0BADF00D);

    // randomized traffic against the model
    auto_new = 1'b1;
    run(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
